crc_frame_checker: RTL and testbench
====================================

// Module: crc_frame_checker
// PURPOSE
//  Parametrised, frame-aware CRC checker: successor to the fixed CRC-8 byte checker.
//  - Consumes a byte stream from the UART receive path: payload bytes, then CRC_W/8 received CRC bytes.
//  - Computes the CRC over the payload only, compares it with the received CRC, and reports one verdict per frame.
//  - Keeps frame, error and abort statistics for the host status registers.
// PARAMETERS
//  CRC_W   8      CRC width in bits; multiple of 8, range 8..32
//  POLY    'h07   generator polynomial, implicit x^CRC_W term omitted, MSB-first
//  INIT    'h00   CRC register value loaded at frame start
//  XOROUT  'h00   value XORed into the final CRC before the compare
//  CNT_W   16     width of the statistics counters
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  s_valid      in   1      byte valid
//  s_ready      out  1      byte accepted when s_valid && s_ready
//  s_data       in   8      stream byte
//  s_last       in   1      marks the LAST PAYLOAD byte; ignored in CRC state
//  abort        in   1      drop the current frame, e.g. on a UART framing error
//  crc_done     out  1      one-cycle pulse: verdict valid
//  crc_ok       out  1      computed CRC == received CRC; held until next crc_done
//  crc_calc     out  CRC_W  computed CRC, XOROUT applied; held
//  crc_rx       out  CRC_W  received CRC, assembled MSB byte first; held
//  frame_cnt    out  CNT_W  frames completed, saturating
//  err_cnt      out  CNT_W  frames with a CRC mismatch, saturating
//  abort_cnt    out  CNT_W  frames aborted, saturating
// BEHAVIOUR
//  Reset: state=IDLE; crc=INIT; s_ready=1; every other output=0; all counters=0.
//  Byte update is MSB-first and non-reflected:
//    c ^= data<<(CRC_W-8), then 8 iterations of: c = c[CRC_W-1] ? (c<<1)^POLY : c<<1.
//    Truncate to CRC_W bits.
//  FSM:
//    IDLE    - First accepted byte: crc=upd(INIT,byte).
//            - s_last=1 -> CRC (1-byte payload); else -> PAYLOAD.
//    PAYLOAD - Each accepted byte: crc=upd(crc,byte).
//            - s_last -> CRC, with byte index k=0.
//    CRC     - Accepted bytes shift into crc_rx: crc_rx={crc_rx,byte}. No CRC update.
//            - On byte k=CRC_W/8-1 -> DONE.
//    DONE    - Single cycle; s_ready=0.
//            - crc_done=1; crc_ok=(crc^XOROUT)==crc_rx; crc_calc=crc^XOROUT.
//            - Increment frame_cnt; increment err_cnt on mismatch.
//            - -> IDLE; crc reloads INIT.
//  Latency: last CRC byte accepted in cycle N -> crc_done pulses in cycle N+1.
//           Next byte can be accepted in cycle N+2.
//  s_ready is 1 in every state except DONE. s_valid with s_ready=0 is held upstream; no byte is lost.
//  Zero-length payload is not supported: the first byte of a frame is always payload.
//  abort, sampled in PAYLOAD or CRC:
//    - -> IDLE; crc=INIT; abort_cnt++; no crc_done.
//    - A byte presented in the same cycle is discarded.
//    - Held outputs are unchanged.
//  abort in IDLE or DONE: no effect. In DONE the verdict completes normally.
//  s_last in CRC state is ignored; the frame length is fixed by CRC_W.
//  Counters saturate at all-ones; no wrap-around.
//  reset mid-frame: the partial frame is discarded and no counter is updated.
// STRUCTURE
//  crc_defs.vh: FSM state encodings; default CRC_W/POLY/INIT/XOROUT sets (CRC8, CRC16_CCITT, CRC32).
//  Sub-module crc_byte_update: combinational next-CRC for one byte, parametrised by CRC_W and POLY.
//  The same sub-module is reused by the planned transmit-side crc_frame_generator.
// TESTING
//  1. CRC_W=8, POLY=07: payload "123456789" (0x31..0x39), CRC byte F4
//     -> crc_done one cycle after F4; crc_ok=1; crc_calc=F4; frame_cnt=1.
//  2. Same frame with CRC byte F5
//     -> crc_ok=0; crc_rx=F5; crc_calc=F4; err_cnt=1.
//  3. CRC_W=16, POLY=1021, INIT=FFFF: "123456789" + 29 B1
//     -> crc_ok=1. With INIT=0000, the pair 31 C3 -> crc_ok=1.
//  4. 1-byte payload 0x01 (s_last on first byte) + CRC 07, CRC-8
//     -> crc_ok=1. Next frame sent back-to-back: s_ready=0 for exactly one cycle.
//  5. abort after 4 payload bytes, then a full good frame
//     -> abort_cnt=1; no crc_done for the aborted frame; the good frame gives crc_ok=1.
//  6. reset asserted mid-CRC state
//     -> all outputs and counters 0; s_ready=1 in the next cycle; a following good frame passes.

Source files
------------

// File: rtl/crc_frame_checker_pkg.sv
// Shared types and default CRC parameter sets for the frame checker and the
// transmit-side generator that will reuse the byte-update block.
package crc_frame_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0]  CRC8_POLY          = 8'h07;
  localparam logic [7:0]  CRC8_INIT          = 8'h00;
  localparam logic [7:0]  CRC8_XOROUT        = 8'h00;
  localparam logic [15:0] CRC16_CCITT_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_XOROUT = 16'h0000;
  localparam logic [31:0] CRC32_POLY         = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT         = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT       = 32'hFFFF_FFFF;

endpackage

// File: rtl/crc_frame_checker_byte_update.sv
// Combinational next-CRC for one byte: MSB-first, non-reflected.
module crc_byte_update #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 'h07
) (
  input  logic [CRC_W-1:0] i_crc,
  input  logic [7:0]       i_data,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] w_c;

  always_comb begin
    w_c = i_crc ^ (CRC_W'(i_data) << (CRC_W - 8));
    for (int i = 0; i < 8; i++)
      w_c = w_c[CRC_W-1] ? ((w_c << 1) ^ POLY) : (w_c << 1);
    o_crc = w_c;
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Frame-aware CRC checker: payload bytes, then CRC_W/8 received CRC bytes,
// one verdict per frame plus saturating frame/error/abort statistics.
module crc_frame_checker
  import crc_frame_checker_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT   = CRC_W'(CRC8_INIT),
  parameter logic [CRC_W-1:0] XOROUT = CRC_W'(CRC8_XOROUT),
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             abort,
  output logic             crc_done,
  output logic             crc_ok,
  output logic [CRC_W-1:0] crc_calc,
  output logic [CRC_W-1:0] crc_rx,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] abort_cnt
);

  localparam int              NB     = CRC_W / 8;
  localparam int              KW     = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(NB - 1);

  state_t           r_state, w_next;
  logic [CRC_W-1:0] r_crc, r_rx_sh;
  logic [KW-1:0]    r_k;
  logic [CRC_W-1:0] w_crc_in, w_crc_nxt, w_rx_nxt, w_calc;
  logic             w_acc, w_abort, w_last_crc;

  assign w_acc      = s_valid && s_ready;
  assign w_abort    = abort && (r_state == ST_PAYLOAD || r_state == ST_CRC);
  assign w_last_crc = (r_state == ST_CRC) && w_acc && !w_abort && (r_k == K_LAST);
  assign w_crc_in   = (r_state == ST_IDLE) ? INIT : r_crc;
  assign w_rx_nxt   = (r_rx_sh << 8) | CRC_W'(s_data);
  assign w_calc     = r_crc ^ XOROUT;

  crc_byte_update #(.CRC_W(CRC_W), .POLY(POLY)) u_upd (
    .i_crc  (w_crc_in),
    .i_data (s_data),
    .o_crc  (w_crc_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_acc) w_next = s_last ? ST_CRC : ST_PAYLOAD;
      ST_PAYLOAD: if (w_abort) w_next = ST_IDLE;
                  else if (w_acc && s_last) w_next = ST_CRC;
      ST_CRC:     if (w_abort) w_next = ST_IDLE;
                  else if (w_last_crc) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = (r_state != ST_DONE);
    crc_done = (r_state == ST_DONE);
  end

  // Verdict and counters are registered on the last CRC byte so they are
  // already valid in the DONE cycle alongside crc_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc     <= INIT;
      r_rx_sh   <= '0;
      r_k       <= '0;
      crc_ok    <= 1'b0;
      crc_calc  <= '0;
      crc_rx    <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      abort_cnt <= '0;
    end else if (w_abort) begin
      r_crc <= INIT;
      r_k   <= '0;
      if (abort_cnt != '1) abort_cnt <= abort_cnt + 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_PAYLOAD: if (w_acc) begin
          r_crc <= w_crc_nxt;
          r_k   <= '0;
        end
        ST_CRC: if (w_acc) begin
          r_rx_sh <= w_rx_nxt;
          r_k     <= r_k + 1'b1;
          if (w_last_crc) begin
            crc_ok   <= (w_calc == w_rx_nxt);
            crc_calc <= w_calc;
            crc_rx   <= w_rx_nxt;
            if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
            if (w_calc != w_rx_nxt && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end
        ST_DONE: r_crc <= INIT;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Scoreboard bench: three checker instances (CRC-8, CRC-16 INIT FFFF,
// CRC-16 INIT 0000 with 2-bit counters to reach saturation).
module tb_crc_frame_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       vld, lst, abt;
  logic [7:0] dat;
  int         sel;

  always #5 clk = ~clk;

  logic [2:0]  rdy_w, done_w, ok_w;
  logic [31:0] calc_w [3];
  logic [31:0] rx_w   [3];
  logic [31:0] fc_w   [3];
  logic [31:0] ec_w   [3];
  logic [31:0] ac_w   [3];

  logic [7:0]  calc0, rx0;
  logic [15:0] calc1, rx1, calc2, rx2;
  logic [15:0] fc0, ec0, ac0, fc1, ec1, ac1;
  logic [1:0]  fc2, ec2, ac2;

  crc_frame_checker #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .CNT_W(16)) u_c8 (
    .clk(clk), .reset(reset), .s_valid(vld && sel == 0), .s_ready(rdy_w[0]), .s_data(dat),
    .s_last(lst), .abort(abt && sel == 0), .crc_done(done_w[0]), .crc_ok(ok_w[0]),
    .crc_calc(calc0), .crc_rx(rx0), .frame_cnt(fc0), .err_cnt(ec0), .abort_cnt(ac0));

  crc_frame_checker #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000), .CNT_W(16)) u_c16a (
    .clk(clk), .reset(reset), .s_valid(vld && sel == 1), .s_ready(rdy_w[1]), .s_data(dat),
    .s_last(lst), .abort(abt && sel == 1), .crc_done(done_w[1]), .crc_ok(ok_w[1]),
    .crc_calc(calc1), .crc_rx(rx1), .frame_cnt(fc1), .err_cnt(ec1), .abort_cnt(ac1));

  crc_frame_checker #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOROUT(16'h0000), .CNT_W(2)) u_c16b (
    .clk(clk), .reset(reset), .s_valid(vld && sel == 2), .s_ready(rdy_w[2]), .s_data(dat),
    .s_last(lst), .abort(abt && sel == 2), .crc_done(done_w[2]), .crc_ok(ok_w[2]),
    .crc_calc(calc2), .crc_rx(rx2), .frame_cnt(fc2), .err_cnt(ec2), .abort_cnt(ac2));

  assign calc_w[0] = 32'(calc0); assign rx_w[0] = 32'(rx0);
  assign calc_w[1] = 32'(calc1); assign rx_w[1] = 32'(rx1);
  assign calc_w[2] = 32'(calc2); assign rx_w[2] = 32'(rx2);
  assign fc_w[0] = 32'(fc0); assign ec_w[0] = 32'(ec0); assign ac_w[0] = 32'(ac0);
  assign fc_w[1] = 32'(fc1); assign ec_w[1] = 32'(ec1); assign ac_w[1] = 32'(ac1);
  assign fc_w[2] = 32'(fc2); assign ec_w[2] = 32'(ec2); assign ac_w[2] = 32'(ac2);

  typedef struct {
    int          sel;
    logic        ok;
    logic [31:0] calc;
    logic [31:0] rx;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  int          last_stall, first_stall;
  logic [31:0] ef[3], ee[3], ea[3];
  logic [31:0] emax[3] = '{32'hFFFF, 32'hFFFF, 32'h3};
  int          wid[3]  = '{8, 16, 16};
  logic [31:0] poly[3] = '{32'h07, 32'h1021, 32'h1021};
  logic [31:0] init[3] = '{32'h00, 32'hFFFF, 32'h0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] crc_sw(input int w, input logic [31:0] p, input logic [31:0] i0,
                                         input logic [7:0] b[$]);
    logic [31:0] c, mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    c = i0;
    foreach (b[n]) begin
      c ^= 32'(b[n]) << (w - 8);
      for (int k = 0; k < 8; k++) c = c[w-1] ? ((c << 1) ^ p) : (c << 1);
      c &= mask;
    end
    return c;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (done_w[k]) begin
          if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = sb.pop_front();
            chk("verdict_inst", k, e.sel);
            chk("crc_ok", 32'(ok_w[k]), 32'(e.ok));
            chk("crc_calc", calc_w[k], e.calc);
            chk("crc_rx", rx_w[k], e.rx);
          end
        end
      end
    end
  end

  // One byte, driven at negedge and accepted on the following ready posedge.
  task automatic put_byte(input int s, input logic [7:0] d, input logic l, input logic fin);
    int n;
    @(negedge clk);
    sel = s; vld = 1'b1; dat = d; lst = l; n = 0;
    while (!rdy_w[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    last_stall = n;
    @(posedge clk);
    #1;
    if (fin) chk("done_latency", 32'(done_w[s]), 32'd1);
  endtask

  task automatic idle(input int cyc);
    @(negedge clk);
    vld = 1'b0; lst = 1'b0; abt = 1'b0;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_frame(input int s, input logic [7:0] pl[$], input logic [7:0] cb[$],
                            input logic [31:0] exp_calc);
    exp_t        e;
    logic [31:0] rx;
    rx = 0;
    foreach (cb[j]) rx = (rx << 8) | 32'(cb[j]);
    e.sel = s; e.ok = (exp_calc == rx); e.calc = exp_calc; e.rx = rx;
    sb.push_back(e);
    if (ef[s] != emax[s]) ef[s]++;
    if (!e.ok && ee[s] != emax[s]) ee[s]++;
    foreach (pl[i]) begin
      put_byte(s, pl[i], i == pl.size() - 1, 1'b0);
      if (i == 0) first_stall = last_stall;
    end
    foreach (cb[j]) put_byte(s, cb[j], 1'b0, j == cb.size() - 1);
  endtask

  task automatic chk_counters(input int s);
    chk("frame_cnt", fc_w[s], ef[s]);
    chk("err_cnt", ec_w[s], ee[s]);
    chk("abort_cnt", ac_w[s], ea[s]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] msg[$], pl[$], cb[$];
    logic [31:0] c, rx;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int k = 0; k < 3; k++) begin ef[k] = 0; ee[k] = 0; ea[k] = 0; end
    reset = 1'b1; vld = 1'b0; lst = 1'b0; abt = 1'b0; dat = 8'h00; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy_w[k]), 32'd1);
      chk("rst_done", 32'(done_w[k]), 32'd0);
      chk("rst_ok", 32'(ok_w[k]), 32'd0);
      chk("rst_calc", calc_w[k], 32'd0);
      chk("rst_rx", rx_w[k], 32'd0);
      chk_counters(k);
    end
    reset = 1'b0;

    send_frame(0, msg, '{8'hF4}, 32'hF4);
    send_frame(0, msg, '{8'hF5}, 32'hF4);
    idle(2);
    chk_counters(0);

    send_frame(1, msg, '{8'h29, 8'hB1}, 32'h29B1);
    send_frame(2, msg, '{8'h31, 8'hC3}, 32'h31C3);
    idle(2);
    chk_counters(1);
    chk_counters(2);

    send_frame(0, '{8'h01}, '{8'h07}, 32'h07);
    send_frame(0, '{8'h01}, '{8'h07}, 32'h07);
    chk("b2b_stall", first_stall, 32'd1);
    idle(2);

    // abort while idle is ignored
    @(negedge clk); sel = 0; abt = 1'b1;
    idle(1);
    chk_counters(0);

    // abort in payload with a byte on the bus; held verdict must survive
    for (int i = 0; i < 4; i++) put_byte(0, msg[i], 1'b0, 1'b0);
    @(negedge clk); sel = 0; vld = 1'b1; dat = 8'hAA; abt = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_done", 32'(done_w[0]), 32'd0);
    ea[0]++;
    idle(2);
    chk_counters(0);
    chk("held_ok", 32'(ok_w[0]), 32'd1);
    chk("held_calc", calc_w[0], 32'h07);
    send_frame(0, msg, '{8'hF4}, 32'hF4);
    idle(2);
    chk_counters(0);

    // abort in CRC state
    foreach (msg[i]) put_byte(1, msg[i], i == 8, 1'b0);
    put_byte(1, 8'h29, 1'b0, 1'b0);
    @(negedge clk); sel = 1; vld = 1'b1; dat = 8'hB1; abt = 1'b1;
    @(posedge clk); #1;
    chk("abort_crc_no_done", 32'(done_w[1]), 32'd0);
    ea[1]++;
    idle(2);
    chk_counters(1);

    // random frames; every third one corrupted
    for (int s = 0; s < 3; s++) begin
      for (int f = 0; f < 6; f++) begin
        pl.delete(); cb.delete();
        for (int i = 0; i < $urandom_range(1, 6); i++) pl.push_back(8'($urandom_range(0, 255)));
        c = crc_sw(wid[s], poly[s], init[s], pl);
        rx = (f % 3 == 0) ? (c ^ 32'h1) : c;
        for (int j = wid[s] / 8 - 1; j >= 0; j--) cb.push_back(8'(rx >> (8 * j)));
        send_frame(s, pl, cb, c);
      end
      idle(2);
      chk_counters(s);
    end

    // reset in the middle of the CRC bytes
    foreach (msg[i]) put_byte(1, msg[i], i == 8, 1'b0);
    put_byte(1, 8'h29, 1'b0, 1'b0);
    @(negedge clk); vld = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ef[k] = 0; ee[k] = 0; ea[k] = 0;
      chk("post_rst_ready", 32'(rdy_w[k]), 32'd1);
      chk("post_rst_ok", 32'(ok_w[k]), 32'd0);
      chk("post_rst_calc", calc_w[k], 32'd0);
      chk_counters(k);
    end
    send_frame(1, msg, '{8'h29, 8'hB1}, 32'h29B1);
    idle(3);
    chk_counters(1);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
